// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate path: default datapath widths
// and the accumulator FSM state encoding.
package mac_pkg;

  localparam int unsigned MAC_DATA_W = 8;
  localparam int unsigned MAC_ACC_W  = 10;
  localparam int unsigned MAC_COUNT  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/product_accumulator_sat_add.sv
// Unsigned saturating adder: acc + addend, clamped to all-ones on carry-out,
// with ovf flagging that the clamp happened.
module sat_add
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W  = MAC_ACC_W,
  parameter int unsigned DATA_W = MAC_DATA_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] addend,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W:0] wide;

  always_comb begin
    wide = {1'b0, acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, addend};
    ovf  = wide[ACC_W];
    sum  = wide[ACC_W] ? '1 : wide[ACC_W-1:0];
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums COUNT incoming products per block into a saturating accumulator and
// presents the block sum, count and overflow flag on a valid/ready output.
module product_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned  DATA_W = MAC_DATA_W,
  parameter int unsigned  ACC_W  = MAC_ACC_W,
  parameter int unsigned  COUNT  = MAC_COUNT,
  localparam int unsigned CNT_W  = $clog2(COUNT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  acc_state_t state, state_next;

  logic [ACC_W-1:0] acc, acc_sum, acc_upd;
  logic [CNT_W-1:0] cnt, cnt_upd;
  logic             ovf, ovf_upd, add_ovf;
  logic             accept;

  sat_add #(
    .ACC_W (ACC_W),
    .DATA_W(DATA_W)
  ) u_sat_add (
    .acc   (acc),
    .addend(in_data),
    .sum   (acc_sum),
    .ovf   (add_ovf)
  );

  // Post-accept view of the block; used both for the next accumulator state
  // and for loading the output registers on the completing edge.
  always_comb begin
    accept  = ena && in_valid && in_ready;
    acc_upd = accept ? acc_sum : acc;
    cnt_upd = cnt + CNT_W'(accept);
    ovf_upd = ovf || (accept && add_ovf);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (ena) begin
      if (clear) begin
        state_next = IDLE;
      end else begin
        case (state)
          IDLE, ACCUM: begin
            if ((accept && cnt_upd == CNT_W'(COUNT)) || (flush && cnt_upd != '0))
              state_next = HOLD;
            else if (cnt_upd != '0)
              state_next = ACCUM;
          end
          HOLD:    if (out_ready) state_next = IDLE;
          default: state_next = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    in_ready = ena && !clear && (state != HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (ena) begin
      if (clear) begin
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
        out_valid <= 1'b0;
      end else if (state == HOLD) begin
        if (out_ready) begin
          acc       <= '0;
          cnt       <= '0;
          ovf       <= 1'b0;
          out_valid <= 1'b0;
        end
      end else begin
        acc <= acc_upd;
        cnt <= cnt_upd;
        ovf <= ovf_upd;
        if (state_next == HOLD) begin
          out_valid <= 1'b1;
          out_sum   <= acc_upd;
          out_count <= cnt_upd;
          out_ovf   <= ovf_upd;
        end
      end
    end
  end

endmodule
